// File: rtl/pipe_pkg.sv
// Shared state and occupancy encodings for the skid-buffered pipeline stage.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_HALF  = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   function automatic logic [1:0] occ_of(input skid_state_t s);
      case (s)
         HALF:    occ_of = OCC_HALF;
         FULL:    occ_of = OCC_FULL;
         default: occ_of = OCC_EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control for the two-entry skid stage: occupancy FSM, register load selects, flush-drop counter.
// Handshake outputs are flops loaded from the next-state decode, so no input reaches them combinationally.
module pipe_skid_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             out_valid,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] drop_count,
   output logic             main_ld_in,
   output logic             main_ld_skid,
   output logic             main_clr,
   output logic             skid_ld,
   output logic             skid_clr
);

   skid_state_t      state;
   skid_state_t      state_nxt;
   logic             in_fire;
   logic             out_fire;
   logic [1:0]       drop_inc;
   logic [CNT_W:0]   drop_sum;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_nxt    = state;
      main_ld_in   = 1'b0;
      main_ld_skid = 1'b0;
      main_clr     = 1'b0;
      skid_ld      = 1'b0;
      skid_clr     = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_nxt  = HALF;
               main_ld_in = 1'b1;
            end
         end
         HALF: begin
            if (in_fire && out_fire) begin
               main_ld_in = 1'b1;
            end else if (in_fire) begin
               state_nxt = FULL;
               skid_ld   = 1'b1;
            end else if (out_fire) begin
               state_nxt = EMPTY;
               main_clr  = 1'b1;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_nxt    = HALF;
               main_ld_skid = 1'b1;
               skid_clr     = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush overrides every load; an out_fire this cycle has already been delivered.
      if (flush) begin
         state_nxt    = EMPTY;
         main_ld_in   = 1'b0;
         main_ld_skid = 1'b0;
         skid_ld      = 1'b0;
         main_clr     = 1'b1;
         skid_clr     = 1'b1;
      end
   end

   // out_fire implies occupancy >= 1, so this never underflows.
   assign drop_inc = occupancy - {1'b0, out_fire};
   assign drop_sum = {1'b0, drop_count} + (CNT_W+1)'(drop_inc);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         occupancy  <= OCC_EMPTY;
         drop_count <= '0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != FULL);
         out_valid <= (state_nxt != EMPTY);
         occupancy <= occ_of(state_nxt);
         if (flush) begin
            drop_count <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer and synchronous flush.
// One cycle latency; when downstream stalls, one extra beat is absorbed before in_ready drops.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 171,
   parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] drop_count
);

   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             main_ld_in;
   logic             main_ld_skid;
   logic             main_clr;
   logic             skid_ld;
   logic             skid_clr;

   pipe_skid_ctrl #(
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .out_ready    (out_ready),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .occupancy    (occupancy),
      .drop_count   (drop_count),
      .main_ld_in   (main_ld_in),
      .main_ld_skid (main_ld_skid),
      .main_clr     (main_clr),
      .skid_ld      (skid_ld),
      .skid_clr     (skid_clr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= NOP_VALUE;
         skid_q <= NOP_VALUE;
      end else begin
         if (main_clr) begin
            main_q <= NOP_VALUE;
         end else if (main_ld_in) begin
            main_q <= in_data;
         end else if (main_ld_skid) begin
            main_q <= skid_q;
         end
         if (skid_clr) begin
            skid_q <= NOP_VALUE;
         end else if (skid_ld) begin
            skid_q <= in_data;
         end
      end
   end

   assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

   localparam int W  = 171;
   localparam int CW = 8;
   localparam int NV = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  in_data, out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] drop_count;

   logic       s_reset, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [7:0] s_in_data, s_out_data;
   logic [1:0] s_occupancy;
   logic [1:0] s_drop_count;

   pipe_stage_skid #(.WIDTH(W), .NOP_VALUE({W{1'b0}}), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .drop_count(drop_count)
   );

   pipe_stage_skid #(.WIDTH(8), .NOP_VALUE(8'h00), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(s_reset), .flush(s_flush),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .occupancy(s_occupancy), .drop_count(s_drop_count)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a FIFO of live payloads plus a saturating drop tally.
   logic [W-1:0] mq[$];
   int           mdrop = 0;

   typedef struct {
      logic         rst, fl, iv, ordy;
      logic [W-1:0] din;
      int           occ;
      logic         rdy, vld;
      logic [W-1:0] dat;
      int           drp;
   } vec_t;

   vec_t tbl[NV];

   function automatic logic [W-1:0] pat(input logic [7:0] k);
      logic [W-1:0] r;
      r = '0;
      r[7:0] = k;
      r[W-1 -: 8] = ~k;
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_data();
      return W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   function automatic vec_t mkv(input logic rst, fl, iv, ordy, input logic [7:0] dk,
                                input int occ, input logic rdy, vld, input logic [7:0] ek,
                                input int drp);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy;
      v.din = pat(dk);
      v.occ = occ; v.rdy = rdy; v.vld = vld;
      v.dat = (ek == 8'h00) ? '0 : pat(ek);
      v.drp = drp;
      return v;
   endfunction

   task automatic model_edge();
      bit inf, outf;
      if (reset) begin
         mq.delete();
         mdrop = 0;
      end else begin
         inf  = in_valid && (mq.size() < 2);
         outf = (mq.size() > 0) && out_ready;
         if (flush) begin
            mdrop = mdrop + mq.size() - (outf ? 1 : 0);
            if (mdrop > (1 << CW) - 1) mdrop = (1 << CW) - 1;
            mq.delete();
         end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(in_data);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic check(input string name, input int occ, input logic rdy, vld,
                        input logic [W-1:0] dat, input int drp);
      bit bad = 0;
      vectors++;
      if (int'(occupancy) != occ) begin
         $display("FAIL %s occupancy got %0d want %0d", name, occupancy, occ); bad = 1;
      end
      if (in_ready !== rdy) begin
         $display("FAIL %s in_ready got %b want %b", name, in_ready, rdy); bad = 1;
      end
      if (out_valid !== vld) begin
         $display("FAIL %s out_valid got %b want %b", name, out_valid, vld); bad = 1;
      end
      if (out_data !== dat) begin
         $display("FAIL %s out_data got %h want %h", name, out_data, dat); bad = 1;
      end
      if (int'(drop_count) != drp) begin
         $display("FAIL %s drop_count got %0d want %0d", name, drop_count, drp); bad = 1;
      end
      if (bad) miscompares++;
   endtask

   task automatic check_model(input string name);
      check(name, mq.size(), mq.size() < 2, mq.size() > 0,
            (mq.size() > 0) ? mq[0] : '0, mdrop);
   endtask

   task automatic sat_check(input string name, input int drp, input int occ);
      vectors++;
      if (int'(s_drop_count) != drp || int'(s_occupancy) != occ) begin
         $display("FAIL %s drop_count got %0d want %0d, occupancy got %0d want %0d",
                  name, s_drop_count, drp, s_occupancy, occ);
         miscompares++;
      end
   endtask

   initial begin
      // rst fl iv or din | occ rdy vld dat drop   (data key 0 = bubble)
      tbl[0]  = mkv(1,0,0,0,8'h00, 0,1,0,8'h00,0);
      tbl[1]  = mkv(0,0,1,1,8'h01, 1,1,1,8'h01,0);
      tbl[2]  = mkv(0,0,1,1,8'h02, 1,1,1,8'h02,0);
      tbl[3]  = mkv(0,0,1,1,8'h03, 1,1,1,8'h03,0);
      tbl[4]  = mkv(0,0,0,1,8'h00, 0,1,0,8'h00,0);
      tbl[5]  = mkv(0,0,1,0,8'hA0, 1,1,1,8'hA0,0);
      tbl[6]  = mkv(0,0,1,0,8'hB0, 2,0,1,8'hA0,0);
      tbl[7]  = mkv(0,0,1,0,8'hC0, 2,0,1,8'hA0,0);
      tbl[8]  = mkv(0,0,0,1,8'h00, 1,1,1,8'hB0,0);
      tbl[9]  = mkv(0,0,0,1,8'h00, 0,1,0,8'h00,0);
      tbl[10] = mkv(0,0,1,0,8'hE0, 1,1,1,8'hE0,0);
      tbl[11] = mkv(0,0,1,1,8'hF0, 1,1,1,8'hF0,0);
      tbl[12] = mkv(0,0,1,0,8'h11, 2,0,1,8'hF0,0);
      tbl[13] = mkv(0,1,1,1,8'h22, 0,1,0,8'h00,1);
      tbl[14] = mkv(0,0,1,0,8'h33, 1,1,1,8'h33,1);
      tbl[15] = mkv(0,1,0,0,8'h00, 0,1,0,8'h00,2);
      tbl[16] = mkv(0,0,1,0,8'h44, 1,1,1,8'h44,2);
      tbl[17] = mkv(0,0,1,0,8'h55, 2,0,1,8'h44,2);
      tbl[18] = mkv(1,1,1,1,8'h66, 0,1,0,8'h00,0);
      tbl[19] = mkv(0,0,1,1,8'h77, 1,1,1,8'h77,0);

      reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
      s_reset = 1; s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_in_data = '0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         reset = tbl[i].rst; flush = tbl[i].fl; in_valid = tbl[i].iv;
         out_ready = tbl[i].ordy; in_data = tbl[i].din;
         cycle();
         check($sformatf("vec%0d", i), tbl[i].occ, tbl[i].rdy, tbl[i].vld,
               tbl[i].dat, tbl[i].drp);
      end

      // Randomized run against the queue model, alternating stall-heavy and flowing phases.
      reset = 1; flush = 0; in_valid = 0; out_ready = 0;
      cycle();
      check_model("rand_reset");
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 23) == 0);
         in_valid  = ($urandom_range(0, 9) < 6);
         out_ready = ((n / 300) % 2 == 0) ? ($urandom_range(0, 9) < 3)
                                          : ($urandom_range(0, 9) < 9);
         in_data   = rnd_data();
         cycle();
         check_model($sformatf("rand%0d", n));
      end
      reset = 0; flush = 0; in_valid = 0; out_ready = 0;

      // Saturation on a 2-bit counter: each flush from FULL with no out_fire drops two.
      s_reset = 1;
      cycle();
      s_reset = 0;
      sat_check("sat_reset", 0, 0);
      for (int k = 0; k < 4; k++) begin
         s_in_valid = 1; s_out_ready = 0; s_flush = 0;
         s_in_data = 8'(k * 2 + 1);
         cycle();
         s_in_data = 8'(k * 2 + 2);
         cycle();
         s_in_valid = 0;
         sat_check($sformatf("sat_fill%0d", k), (k == 0) ? 0 : 3 - (k == 1 ? 1 : 0), 2);
         s_flush = 1;
         cycle();
         s_flush = 0;
         sat_check($sformatf("sat_flush%0d", k), (2 * (k + 1) > 3) ? 3 : 2 * (k + 1), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush. It sits between processor pipeline stages, such as IF/ID, ID/EX, EX/MEM and MEM/WB. It generalises the fixed-width, enable-only stage register: the width is selectable, backpressure is handled without a combinational ready path, flush inserts a bubble, and a counter records how many entries each flush discards.

## Interface
- WIDTH, 171, payload width in bits (≥1)
- NOP_VALUE, {WIDTH{1'b0}}, payload presented when the stage is empty or flushed (the bubble)
- CNT_W, 8, width of the flush-drop counter

- clk  input  1  rising-edge clock; only clock in the block
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept; driven from state only
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a live entry
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  head payload; NOP_VALUE when empty
- occupancy  output  2  live entries held (0, 1 or 2)
- drop_count  output  CNT_W  saturating count of live entries killed by flush

## Operation
- Storage is two WIDTH-bit registers: main, which drives out_data, and skid.
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- FSM states: EMPTY (occupancy 0), HALF (1), FULL (2).
- Derived outputs: in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY:
  - in_fire → HALF, main ← in_data.
- HALF:
  - in_fire & out_fire → HALF, main ← in_data.
  - in_fire & !out_fire → FULL, skid ← in_data.
  - !in_fire & out_fire → EMPTY, main ← NOP_VALUE.
  - otherwise hold.
- FULL:
  - out_fire → HALF, main ← skid, skid ← NOP_VALUE.
  - otherwise hold.
  - in_ready = 0, so no input is taken.
- Ordering is strict FIFO; entries are never reordered or duplicated.
- Flush:
  - Next state is EMPTY; main and skid ← NOP_VALUE.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still completes downstream, because the data was already presented.
  - drop_count += occupancy − (out_fire ? 1 : 0), saturating at 2^CNT_W−1.
- Reset:
  - Highest priority, above flush.
  - state ← EMPTY; main and skid ← NOP_VALUE; drop_count ← 0.
  - Handshakes in a reset cycle are ignored.
- Reset values after the reset edge: in_ready = 1, out_valid = 0, out_data = NOP_VALUE, occupancy = 0, drop_count = 0.

## Timing
- Latency: in_fire in cycle N into EMPTY → out_valid = 1 with that data in cycle N+1.
- Throughput: one transfer per cycle in steady state with out_ready held high. The skid register is unused in that case.
- Backpressure: in_ready falls the cycle after the second entry is accepted while out_ready = 0. At most one extra beat is absorbed, in the skid register.
- No combinational path from out_ready to in_ready, or from in_* to out_*. All outputs come from flops or from the state decode.
- Flush takes effect at the next edge. From cycle N+1: out_valid = 0, in_ready = 1.
- Reset arriving mid-transfer, including in FULL: both entries are silently lost and are not counted in drop_count.

## Structure
- Shared package pipe_pkg holds:
  - typedef skid_state_t {EMPTY, HALF, FULL}, 2 bits.
  - The occupancy encoding constants.
- One sub-module is natural: pipe_skid_ctrl. It contains the FSM, the in_ready and out_valid decode, the register load selects (main_ld_in, main_ld_skid, main_clr, skid_ld, skid_clr), and drop_count. The pipe_stage_skid top holds the WIDTH-wide datapath registers and muxes.
- drop_count is a separate saturating counter. It resets only on reset, never on flush.

## Test plan
- Pass-through, WIDTH=171:
  - Stimulus: after reset, out_ready = 1; send 0x…01, 0x…02, 0x…03 on consecutive cycles.
  - Required: each appears on out_data exactly one cycle after its accept; occupancy stays ≤ 1; in_ready is never 0.
- Backpressure fill/drain:
  - Stimulus: out_ready = 0; send A then B.
  - Required: occupancy reaches 2 and in_ready = 0 in the cycle after B is accepted.
  - Stimulus: raise out_ready.
  - Required: out_data shows A then B on successive cycles; state returns to EMPTY with out_data = NOP_VALUE.
- Simultaneous events in HALF:
  - Stimulus: in_fire and out_fire in the same cycle.
  - Required: state stays HALF and main takes the new data.
- Flush in FULL with out_ready = 1 and in_valid = 1:
  - Required next cycle: EMPTY; out_data = NOP_VALUE; incoming beat discarded; drop_count += 1.
- Saturation, CNT_W = 2:
  - Stimulus: four flushes from FULL with out_ready = 0.
  - Required: drop_count reads 2, then 3, 3, 3.
- Reset mid-operation:
  - Stimulus: assert reset in FULL together with flush.
  - Required next cycle: all outputs at their reset values; drop_count = 0.
